// File: rtl/lsu_align.sv
// Load/store alignment unit: lane shifting, byte enables and load extension for
// B/H/W/D accesses, with optional splitting of word-crossing accesses.
module lsu_align #(
  parameter int XLEN           = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault
);

  // state   | meaning
  // IDLE    | ready for a new request
  // REQ1    | first (or only) memory request, held until grant
  // WAIT1   | waiting for the first response
  // REQ2    | second half of a word-crossing access
  // WAIT2   | waiting for the second response
  // RESP    | one-cycle completion pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ1  = 3'd1;
  localparam logic [2:0] S_WAIT1 = 3'd2;
  localparam logic [2:0] S_REQ2  = 3'd3;
  localparam logic [2:0] S_WAIT2 = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int EW   = OFFW + 2;
  localparam int BW   = 2 * NB;
  localparam logic [1:0] MAX_SIZE = 2'(OFFW);

  logic [2:0]      state, state_nxt;
  logic            we_q, uns_q, fault_q, cross_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q, rd1_q, rd2_q;

  logic [OFFW-1:0] in_off;
  logic [EW-1:0]   in_end;
  logic            in_cross, in_fault, accept;

  assign in_off   = req_addr[OFFW-1:0];
  assign in_end   = EW'(in_off) + (EW'(1) << req_size);
  assign in_cross = in_end > EW'(NB);
  assign in_fault = (req_size > MAX_SIZE) || (in_cross && !MISALIGN_SPLIT);
  assign accept   = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = in_fault ? S_RESP : S_REQ1;
      S_REQ1:  if (mem_gnt) state_nxt = S_WAIT1;
      S_WAIT1: if (mem_rvalid) state_nxt = cross_q ? S_REQ2 : S_RESP;
      S_REQ2:  if (mem_gnt) state_nxt = S_WAIT2;
      S_WAIT2: if (mem_rvalid) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      cross_q <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        fault_q <= in_fault;
        cross_q <= in_cross && !in_fault;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == S_WAIT1 && mem_rvalid) rd1_q <= mem_rdata;
      if (state == S_WAIT2 && mem_rvalid) rd2_q <= mem_rdata;
    end
  end

  // Both accesses are slices of one double-width window shifted by the offset:
  // the low half feeds access 1, the high half access 2.
  logic [OFFW-1:0]   off;
  logic [3:0]        nbytes;
  logic [BW-1:0]     be_base, be_full;
  logic [2*XLEN-1:0] wd_full, rd_pair;
  logic [XLEN-1:0]   base_addr, raw, keep, ext;
  logic              sign;

  assign off       = addr_q[OFFW-1:0];
  assign nbytes    = 4'd1 << size_q;
  assign be_base   = (BW'(1) << nbytes) - BW'(1);
  assign be_full   = be_base << off;
  assign wd_full   = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
  assign base_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign rd_pair   = {(cross_q ? rd2_q : {XLEN{1'b0}}), rd1_q} >> {off, 3'b000};
  assign raw       = rd_pair[XLEN-1:0];

  always_comb begin
    case (size_q)
      2'd0:    begin keep = XLEN'(8'hFF);         sign = raw[7];      end
      2'd1:    begin keep = XLEN'(16'hFFFF);      sign = raw[15];     end
      2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sign = raw[31];     end
      default: begin keep = '1;                   sign = raw[XLEN-1]; end
    endcase
    ext = (raw & keep) | ((uns_q || !sign) ? '0 : ~keep);
  end

  assign req_ready = (state == S_IDLE);
  assign mem_req   = (state == S_REQ1) || (state == S_REQ2);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = (state == S_REQ1) ? base_addr :
                     (state == S_REQ2) ? base_addr + XLEN'(NB) : '0;
  assign mem_be    = (state == S_REQ1) ? be_full[NB-1:0] :
                     (state == S_REQ2) ? be_full[BW-1:NB] : '0;
  assign mem_wdata = !mem_we ? '0 :
                     (state == S_REQ1) ? wd_full[XLEN-1:0] : wd_full[2*XLEN-1:XLEN];
  assign rsp_valid = (state == S_RESP);
  assign rsp_fault = rsp_valid && fault_q;
  assign rsp_rdata = (rsp_valid && !we_q && !fault_q) ? ext : '0;

endmodule
